// File: rtl/cajero_pkg.sv
// Shared constants for the PIN entry path: one-hot FSM encodings, BCD digit limits
// and the attempt-counter width helper.
package cajero_pkg;

  localparam int unsigned ESTADO_W = 4;
  localparam logic [ESTADO_W-1:0] ST_IDLE       = 4'b0001;
  localparam logic [ESTADO_W-1:0] ST_RECIBIENDO = 4'b0010;
  localparam logic [ESTADO_W-1:0] ST_COMPARAR   = 4'b0100;
  localparam logic [ESTADO_W-1:0] ST_BLOQUEO    = 4'b1000;

  localparam int unsigned DIGITO_W = 4;
  localparam logic [DIGITO_W-1:0] DIGITO_MAX = 4'd9;

  function automatic int unsigned intentos_w(input int unsigned max_intentos);
    return $clog2(max_intentos + 1);
  endfunction

endpackage

// File: rtl/pin_shift_reg.sv
// Digit collector: shifts accepted BCD digits in from the right and counts them;
// lleno_c flags the strobe that completes the PIN.
module pin_shift_reg
  import cajero_pkg::*;
#(
  parameter int unsigned PIN_DIGITS = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           shift_en,
  input  logic [DIGITO_W-1:0]            digito,
  output logic [DIGITO_W*PIN_DIGITS-1:0] datos,
  output logic                           lleno_c
);

  localparam int unsigned PIN_W = DIGITO_W * PIN_DIGITS;
  localparam int unsigned CNT_W = $clog2(PIN_DIGITS + 1);

  logic [CNT_W-1:0] cuenta;

  // Shift-based insert keeps the first-entered digit in the MS nibble for any width.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      datos  <= '0;
      cuenta <= '0;
    end else if (shift_en) begin
      datos  <= (datos << DIGITO_W) | PIN_W'(digito);
      cuenta <= cuenta + CNT_W'(1);
    end
  end

  assign lleno_c = shift_en && (cuenta == CNT_W'(PIN_DIGITS - 1));

endmodule

// File: rtl/pin_verifier.sv
// PIN entry and verification FSM with failed-attempt counting, warning and lockout.
// Optional inactivity timeout in RECIBIENDO is enabled by defining PIN_TIMEOUT_EN.
module pin_verifier
  import cajero_pkg::*;
#(
  parameter int unsigned PIN_DIGITS     = 4,
  parameter int unsigned MAX_INTENTOS   = 3,
  parameter int unsigned TIMEOUT_CICLOS = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                tarjeta_recibida,
  input  logic                                digito_stb,
  input  logic [DIGITO_W-1:0]                 digito,
  input  logic [DIGITO_W*PIN_DIGITS-1:0]      pin_correcto,
  output logic                                pin_ok,
  output logic                                pin_error,
  output logic                                advertencia,
  output logic                                bloqueo,
  output logic                                fin,
  output logic [intentos_w(MAX_INTENTOS)-1:0] intentos
);

  localparam int unsigned PIN_W = DIGITO_W * PIN_DIGITS;
  localparam int unsigned INT_W = intentos_w(MAX_INTENTOS);

  if (PIN_DIGITS < 1 || PIN_DIGITS > 8 || MAX_INTENTOS < 2 || MAX_INTENTOS > 15 ||
      TIMEOUT_CICLOS < 1) begin : g_param_check
    $error("pin_verifier: parameter out of range");
  end

  logic [ESTADO_W-1:0] state, state_d;
  logic                pin_ok_d, pin_error_d, fin_d, advertencia_d, bloqueo_d;
  logic [INT_W-1:0]    intentos_d;
  logic                fallo_c;
  logic                acepta_c, lleno_c, clear_c, timeout_c;
  logic [PIN_W-1:0]    datos;

  // Only digits strobed while the card stays present in RECIBIENDO are taken.
  assign acepta_c = (state == ST_RECIBIENDO) && tarjeta_recibida && digito_stb &&
                    (digito <= DIGITO_MAX);
  assign clear_c  = (state != ST_RECIBIENDO) || timeout_c;

  pin_shift_reg #(
    .PIN_DIGITS (PIN_DIGITS)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_c),
    .shift_en (acepta_c),
    .digito   (digito),
    .datos    (datos),
    .lleno_c  (lleno_c)
  );

`ifdef PIN_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CICLOS + 1);
  logic [TMR_W-1:0] tmr;

  // Inactivity timer, reloaded on entry to RECIBIENDO, on each accepted digit and on expiry.
  always_ff @(posedge clk) begin
    if (reset || (state != ST_RECIBIENDO) || acepta_c || timeout_c) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + TMR_W'(1);
    end
  end

  assign timeout_c = (state == ST_RECIBIENDO) && tarjeta_recibida && !acepta_c &&
                     (tmr == TMR_W'(TIMEOUT_CICLOS - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pin_ok      <= 1'b0;
      pin_error   <= 1'b0;
      fin         <= 1'b0;
      advertencia <= 1'b0;
      bloqueo     <= 1'b0;
      intentos    <= '0;
    end else begin
      state       <= state_d;
      pin_ok      <= pin_ok_d;
      pin_error   <= pin_error_d;
      fin         <= fin_d;
      advertencia <= advertencia_d;
      bloqueo     <= bloqueo_d;
      intentos    <= intentos_d;
    end
  end

  always_comb begin
    state_d       = ST_IDLE;
    pin_ok_d      = 1'b0;
    pin_error_d   = 1'b0;
    fin_d         = 1'b0;
    advertencia_d = advertencia;
    bloqueo_d     = bloqueo;
    intentos_d    = intentos;
    fallo_c       = 1'b0;

    case (state)
      ST_IDLE: begin
        state_d = tarjeta_recibida ? ST_RECIBIENDO : ST_IDLE;
      end
      ST_RECIBIENDO: begin
        if (!tarjeta_recibida) begin
          state_d = ST_IDLE;
        end else if (lleno_c) begin
          state_d = ST_COMPARAR;
        end else if (timeout_c) begin
          fallo_c = 1'b1;
        end else begin
          state_d = ST_RECIBIENDO;
        end
      end
      ST_COMPARAR: begin
        if (datos == pin_correcto) begin
          pin_ok_d      = 1'b1;
          fin_d         = 1'b1;
          intentos_d    = '0;
          advertencia_d = 1'b0;
          state_d       = ST_IDLE;
        end else begin
          fallo_c = 1'b1;
        end
      end
      ST_BLOQUEO: begin
        state_d   = ST_BLOQUEO;
        bloqueo_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Shared failed-attempt handling for a mismatch or an expired timer.
    if (fallo_c) begin
      pin_error_d = 1'b1;
      intentos_d  = intentos + INT_W'(1);
      if (intentos_d == INT_W'(MAX_INTENTOS)) begin
        bloqueo_d     = 1'b1;
        fin_d         = 1'b1;
        advertencia_d = 1'b0;
        state_d       = ST_BLOQUEO;
      end else begin
        advertencia_d = (intentos_d == INT_W'(MAX_INTENTOS - 1));
        state_d       = ST_RECIBIENDO;
      end
    end
  end

endmodule

// File: tb/tb_pin_verifier.sv
// Scoreboard bench for pin_verifier: expected result pulses are queued as PINs are
// keyed in and popped when pin_ok/pin_error fire; levels are checked inline per test.
module tb_pin_verifier;

  localparam int unsigned PIN_DIGITS     = 4;
  localparam int unsigned MAX_INTENTOS   = 3;
  localparam int unsigned TIMEOUT_CICLOS = 20;
  localparam int unsigned INT_W          = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tarjeta_recibida = 1'b0;
  logic             digito_stb = 1'b0;
  logic [3:0]       digito = 4'd0;
  logic [15:0]      pin_correcto = 16'h1234;
  logic             pin_ok, pin_error, advertencia, bloqueo, fin;
  logic [INT_W-1:0] intentos;

  typedef struct packed {
    logic             ok;
    logic             err;
    logic             fin;
    logic [INT_W-1:0] intentos;
    logic             adv;
    logic             blq;
  } res_t;

  res_t exp_q[$];
  res_t mon_got, mon_exp;
  int   checks = 0;
  int   failures = 0;
  int   m_int = 0;

  pin_verifier #(
    .PIN_DIGITS     (PIN_DIGITS),
    .MAX_INTENTOS   (MAX_INTENTOS),
    .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tarjeta_recibida (tarjeta_recibida),
    .digito_stb       (digito_stb),
    .digito           (digito),
    .pin_correcto     (pin_correcto),
    .pin_ok           (pin_ok),
    .pin_error        (pin_error),
    .advertencia      (advertencia),
    .bloqueo          (bloqueo),
    .fin              (fin),
    .intentos         (intentos)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every result pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (pin_ok || pin_error)) begin
      mon_got = {pin_ok, pin_error, fin, intentos, advertencia, bloqueo};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected got=%b required=none t=%0t", mon_got, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL result_pulse got=%b required=%b (ok,err,fin,int,adv,blq) t=%0t",
                   mon_got, mon_exp, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    digito     = d;
    digito_stb = 1'b1;
    @(negedge clk);
    digito_stb = 1'b0;
  endtask

  // Keys in a full PIN, optionally with an invalid digit before position bad_at.
  task automatic enter_pin(input logic [15:0] p, input int bad_at, input logic [3:0] bad_val);
    res_t       e;
    logic [3:0] d;
    e = '0;
    if (p == pin_correcto) begin
      e.ok  = 1'b1;
      e.fin = 1'b1;
      m_int = 0;
    end else begin
      m_int++;
      e.err = 1'b1;
      if (m_int == int'(MAX_INTENTOS)) begin
        e.fin = 1'b1;
        e.blq = 1'b1;
      end else begin
        e.adv = (m_int == int'(MAX_INTENTOS) - 1);
      end
    end
    e.intentos = INT_W'(m_int);
    exp_q.push_back(e);
    for (int i = 3; i >= 0; i--) begin
      if (i == bad_at) press(bad_val);
      d = p[i*4 +: 4];
      press(d);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tarjeta_recibida = 1'b0;
    tick(3);
    checks++;
    if ({pin_ok, pin_error, fin, advertencia, bloqueo} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=00000", {pin_ok, pin_error, fin, advertencia, bloqueo});
    end
    checks++;
    if (intentos !== '0) begin
      failures++;
      $display("FAIL reset_intentos got=%0d required=0", intentos);
    end
    reset = 1'b0;
    m_int = 0;
    tick(1);
  endtask

  task automatic test_idle_strobes;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    tick(3);
    checks++;
    if ({pin_ok, pin_error, intentos} !== 4'b0) begin
      failures++;
      $display("FAIL idle_strobes got=%b required=0000", {pin_ok, pin_error, intentos});
    end
  endtask

  task automatic test_correct_pin;
    tarjeta_recibida = 1'b1;
    press(4'd1);
    enter_pin(16'h1234, -1, 4'h0);
    checks++;
    if (pin_ok !== 1'b0) begin
      failures++;
      $display("FAIL latency_early pin_ok got=%b required=0", pin_ok);
    end
    tick(1);
    checks++;
    if ({pin_ok, fin, intentos} !== 4'b1100) begin
      failures++;
      $display("FAIL latency_pulse ok,fin,int got=%b required=1100", {pin_ok, fin, intentos});
    end
    tick(1);
    checks++;
    if ({pin_ok, fin} !== 2'b00) begin
      failures++;
      $display("FAIL pulse_width ok,fin got=%b required=00", {pin_ok, fin});
    end
    tarjeta_recibida = 1'b0;
    tick(2);
  endtask

  task automatic test_wrong_then_ok;
    tarjeta_recibida = 1'b1;
    tick(1);
    enter_pin(16'h1235, -1, 4'h0);
    tick(3);
    checks++;
    if ({intentos, advertencia} !== 3'b010) begin
      failures++;
      $display("FAIL first_error int,adv got=%b required=010", {intentos, advertencia});
    end
    enter_pin(16'h1236, -1, 4'h0);
    tick(3);
    checks++;
    if ({intentos, advertencia} !== 3'b101) begin
      failures++;
      $display("FAIL warning int,adv got=%b required=101", {intentos, advertencia});
    end
    enter_pin(16'h1234, -1, 4'h0);
    tick(3);
    checks++;
    if ({intentos, advertencia} !== 3'b000) begin
      failures++;
      $display("FAIL recovery int,adv got=%b required=000", {intentos, advertencia});
    end
    tarjeta_recibida = 1'b0;
    tick(2);
  endtask

  task automatic test_bad_digit;
    tarjeta_recibida = 1'b1;
    tick(1);
    enter_pin(16'h1234, 2, 4'hA);
    tick(3);
    enter_pin(16'h1234, 0, 4'hF);
    tick(3);
    checks++;
    if (intentos !== '0) begin
      failures++;
      $display("FAIL bad_digit intentos got=%0d required=0", intentos);
    end
    tarjeta_recibida = 1'b0;
    tick(2);
  endtask

  task automatic test_card_removal;
    tarjeta_recibida = 1'b1;
    tick(1);
    enter_pin(16'h1111, -1, 4'h0);
    tick(3);
    press(4'd1); press(4'd2);
    tarjeta_recibida = 1'b0;
    tick(2);
    checks++;
    if ({intentos, pin_error} !== 3'b010) begin
      failures++;
      $display("FAIL removal_hold int,err got=%b required=010", {intentos, pin_error});
    end
    tarjeta_recibida = 1'b1;
    tick(1);
    enter_pin(16'h1234, -1, 4'h0);
    tick(3);
    checks++;
    if (intentos !== '0) begin
      failures++;
      $display("FAIL reinsert intentos got=%0d required=0", intentos);
    end
    enter_pin(16'h5555, -1, 4'h0);
    tick(3);
    press(4'd1); press(4'd2);
    reset = 1'b1;
    tarjeta_recibida = 1'b0;
    tick(2);
    checks++;
    if ({intentos, advertencia, pin_ok, pin_error} !== 5'b0) begin
      failures++;
      $display("FAIL mid_entry_reset int,adv,ok,err got=%b required=00000",
               {intentos, advertencia, pin_ok, pin_error});
    end
    reset = 1'b0;
    m_int = 0;
    tick(1);
  endtask

  task automatic test_lockout;
    tarjeta_recibida = 1'b1;
    tick(1);
    for (int k = 0; k < 3; k++) begin
      enter_pin(16'h9999, -1, 4'h0);
      tick(3);
    end
    checks++;
    if ({bloqueo, intentos, advertencia} !== 4'b1110) begin
      failures++;
      $display("FAIL lockout blq,int,adv got=%b required=1110", {bloqueo, intentos, advertencia});
    end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    tarjeta_recibida = 1'b0;
    tick(2);
    tarjeta_recibida = 1'b1;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    tick(4);
    checks++;
    if ({bloqueo, intentos, fin} !== 4'b1110) begin
      failures++;
      $display("FAIL lock_sticky blq,int,fin got=%b required=1110", {bloqueo, intentos, fin});
    end
    reset = 1'b1;
    tarjeta_recibida = 1'b0;
    tick(2);
    checks++;
    if ({pin_ok, pin_error, fin, advertencia, bloqueo, intentos} !== 7'b0) begin
      failures++;
      $display("FAIL lock_reset got=%b required=0000000",
               {pin_ok, pin_error, fin, advertencia, bloqueo, intentos});
    end
    reset = 1'b0;
    m_int = 0;
    tick(1);
  endtask

`ifdef PIN_TIMEOUT_EN
  task automatic test_timeout;
    res_t e;
    tarjeta_recibida = 1'b1;
    tick(1);
    press(4'd1); press(4'd2);
    m_int = 1;
    e = '0;
    e.err = 1'b1;
    e.intentos = INT_W'(1);
    exp_q.push_back(e);
    tick(19);
    checks++;
    if (pin_error !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early pin_error got=%b required=0", pin_error);
    end
    tick(3);
    checks++;
    if (intentos !== INT_W'(1)) begin
      failures++;
      $display("FAIL timeout_count intentos got=%0d required=1", intentos);
    end
    enter_pin(16'h1234, -1, 4'h0);
    tick(3);
    tarjeta_recibida = 1'b0;
    tick(2);
  endtask
`endif

  initial begin
    test_reset;
    test_idle_strobes;
    test_correct_pin;
    test_wrong_then_ok;
    test_bad_digit;
    test_card_removal;
    test_lockout;
`ifdef PIN_TIMEOUT_EN
    test_timeout;
`endif
    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_results pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
